// File: rtl/axis_stream_master.sv
// AXI4-Stream frame transmitter programmed through an AXI4-Lite register file.
// Emits incrementing-data frames terminated by TLAST, single-shot or continuous.
module axis_stream_master #(
    parameter int C_S00_AXI_DATA_WIDTH   = 32,
    parameter int C_S00_AXI_ADDR_WIDTH   = 4,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETN,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]       s00_axi_awaddr,
    input  logic [2:0]                            s00_axi_awprot,
    input  logic                                  s00_axi_awvalid,
    output logic                                  s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]       s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]     s00_axi_wstrb,
    input  logic                                  s00_axi_wvalid,
    output logic                                  s00_axi_wready,
    output logic [1:0]                            s00_axi_bresp,
    output logic                                  s00_axi_bvalid,
    input  logic                                  s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]       s00_axi_araddr,
    input  logic [2:0]                            s00_axi_arprot,
    input  logic                                  s00_axi_arvalid,
    output logic                                  s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]       s00_axi_rdata,
    output logic [1:0]                            s00_axi_rresp,
    output logic                                  s00_axi_rvalid,
    input  logic                                  s00_axi_rready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tlast,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic                                  dbg_state_o
);

    localparam int W = C_M00_AXIS_TDATA_WIDTH;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    // Handshake rules: a write is taken on the edge where awready_q is high with
    // AWVALID/WVALID still asserted; a read on the edge where arready_q meets ARVALID.
    // TVALID/TDATA/TLAST only change on edges where TVALID&TREADY or TVALID is low.
    logic        awready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0] rdata_q;
    logic        wr_en, rd_en;
    logic [31:0] rd_mux;

    state_t      state_q;
    logic        start_q, cont_q;
    logic [15:0] len_reg_q, len_q, count_q, frames_q;
    logic [31:0] seed_q;
    logic [W-1:0] tdata_q;
    logic        tvalid_q, tlast_q;
    logic [15:0] len_eff;
    logic [W-1:0] seed_w;
    logic        unused_ok;

    assign wr_en   = awready_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_en   = arready_q & s00_axi_arvalid;
    assign len_eff = (len_reg_q == 16'd0) ? 16'd1 : len_reg_q;
    assign seed_w  = W'(seed_q);

    always_comb begin
        rd_mux = 32'd0;
        case (s00_axi_araddr[3:2])
            2'd0:    rd_mux = {30'd0, cont_q, start_q};
            2'd1:    rd_mux = {16'd0, len_reg_q};
            2'd2:    rd_mux = seed_q;
            default: rd_mux = {frames_q, 15'd0, (state_q == SEND)};
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            awready_q <= !awready_q && s00_axi_awvalid && s00_axi_wvalid && !bvalid_q;
            if (wr_en)
                bvalid_q <= 1'b1;
            else if (s00_axi_bready)
                bvalid_q <= 1'b0;
            arready_q <= !arready_q && s00_axi_arvalid && !rvalid_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Register writes come first so the FSM's START consumption below wins.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            cont_q    <= 1'b0;
            len_reg_q <= 16'd0;
            seed_q    <= 32'd0;
            frames_q  <= 16'd0;
            len_q     <= 16'd0;
            count_q   <= 16'd0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                case (s00_axi_awaddr[3:2])
                    2'd0: if (s00_axi_wstrb[0]) begin
                        cont_q <= s00_axi_wdata[1];
                        if (state_q == IDLE) start_q <= s00_axi_wdata[0];
                    end
                    2'd1: begin
                        if (s00_axi_wstrb[0]) len_reg_q[7:0]  <= s00_axi_wdata[7:0];
                        if (s00_axi_wstrb[1]) len_reg_q[15:8] <= s00_axi_wdata[15:8];
                    end
                    2'd2: for (int b = 0; b < 4; b++)
                        if (s00_axi_wstrb[b]) seed_q[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                    default: ;
                endcase
            end
            case (state_q)
                IDLE: if (start_q) begin
                    state_q  <= SEND;
                    start_q  <= 1'b0;
                    len_q    <= len_eff;
                    count_q  <= 16'd0;
                    tdata_q  <= seed_w;
                    tlast_q  <= (len_eff == 16'd1);
                    tvalid_q <= 1'b1;
                end
                default: if (m00_axis_tready) begin
                    if (tlast_q) begin
                        frames_q <= frames_q + 16'd1;
                        if (cont_q) begin
                            len_q   <= len_eff;
                            count_q <= 16'd0;
                            tdata_q <= seed_w;
                            tlast_q <= (len_eff == 16'd1);
                        end else begin
                            state_q  <= IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                        end
                    end else begin
                        tdata_q <= tdata_q + W'(1);
                        count_q <= count_q + 16'd1;
                        tlast_q <= (count_q + 16'd2 == len_q);
                    end
                end
            endcase
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign s00_axi_rvalid  = rvalid_q;
    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tstrb  = '1;
    assign m00_axis_tlast  = tlast_q;
    assign m00_axis_tvalid = tvalid_q;
    assign dbg_state_o     = state_q;

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_axis_stream_master.sv
// Directed bench for axis_stream_master: register access, single/continuous
// frames, backpressure, length/seed corner cases and mid-frame reset.
module tb_axis_stream_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast, tvalid, tready, dbg_state;

    always #5 clk = ~clk;

    axis_stream_master dut (
        .ACLK(clk), .ARESETN(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb), .m00_axis_tlast(tlast),
        .m00_axis_tvalid(tvalid), .m00_axis_tready(tready),
        .dbg_state_o(dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // TREADY: mode 0 holds high, mode 1 accepts one cycle in four.
    int tready_mode = 0;
    int tr_phase    = 0;
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (tready_mode == 0) tready = 1'b1;
            else begin
                tready   = (tr_phase == 0);
                tr_phase = (tr_phase + 1) % 4;
            end
        end
    end

    // Stream scoreboard: {tlast, tdata} per accepted beat.
    logic [32:0] exp_q[$];
    logic [32:0] mon_e, prev_beat;
    logic        prev_stall = 1'b0, last_tlast = 1'b0;
    int          beats_seen = 0;
    longint      cyc = 0, first_cyc = 0, last_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                check("stall_valid_held", tvalid, 1);
                check("stall_beat_held", {tlast, tdata}, prev_beat);
            end
            if (tvalid && tready) begin
                if (beats_seen == 0) first_cyc = cyc;
                last_cyc   = cyc;
                last_tlast = tlast;
                beats_seen++;
                if (exp_q.size() == 0) check("extra_beat", tvalid, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("beat", {tlast, tdata}, mon_e);
                end
            end
            prev_stall = tvalid && !tready;
            prev_beat  = {tlast, tdata};
        end
    end

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        int t = 0;
        @(posedge clk); #1;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        do begin @(negedge clk); t++; end while (!awready && t < 20);
        if (!awready) check("aw_timeout", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bvalid && t < 10);
        check("bvalid_bresp", {bvalid, bresp}, 3'b100);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int t = 0;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1;
        do begin @(negedge clk); t++; end while (!arready && t < 20);
        if (!arready) check("ar_timeout", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!rvalid && t < 10);
        check("rvalid_rresp", {rvalid, rresp}, 3'b100);
        data = rdata;
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin @(negedge clk); t++; end
        check({tag, "_drained"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_idle_after_last"}, tvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int frames_exp;
        frames_exp = 0;

        // Reset values
        #12;
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tstrb", tstrb, 4'hF);
        check("rst_lite_hs", {awready, wready, bvalid, arready, rvalid}, 0);
        check("rst_rdata", rdata, 0);
        #11 rst_n = 1'b1;
        read_check("rst_ctrl", 4'h0, 32'h0);
        read_check("rst_length", 4'h4, 32'h0);
        read_check("rst_seed", 4'h8, 32'h0);
        read_check("rst_status", 4'hC, 32'h0);

        // Byte strobes on SEED and the ignored upper LENGTH bits
        axi_write(4'h8, 32'hAABBCCDD, 4'b0101);
        read_check("seed_wstrb", 4'h8, 32'h00BB00DD);
        axi_write(4'h4, 32'hFFFF0003, 4'hF);
        read_check("length_upper_zero", 4'h4, 32'h00000003);

        // Single 4-beat frame, TREADY high
        axi_write(4'h4, 32'd4, 4'hF);
        axi_write(4'h8, 32'd1, 4'hF);
        exp_q.push_back({1'b0, 32'd1}); exp_q.push_back({1'b0, 32'd2});
        exp_q.push_back({1'b0, 32'd3}); exp_q.push_back({1'b1, 32'd4});
        axi_write(4'h0, 32'h1, 4'hF);
        drain("frame4");
        frames_exp++;
        read_check("status_after_frame4", 4'hC, {frames_exp[15:0], 16'h0});

        // Same frame under backpressure; START and LENGTH written mid-frame
        tready_mode = 1;
        exp_q.push_back({1'b0, 32'd1}); exp_q.push_back({1'b0, 32'd2});
        exp_q.push_back({1'b0, 32'd3}); exp_q.push_back({1'b1, 32'd4});
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'd9, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        drain("stalled");
        tready_mode = 0;
        frames_exp++;
        read_check("start_while_busy_dropped", 4'h0, 32'h0);
        read_check("status_after_stalled", 4'hC, {frames_exp[15:0], 16'h0});
        repeat (5) @(negedge clk);
        check("no_phantom_frame", tvalid, 0);

        // LENGTH=0 acts as 1; then a 2-beat frame wrapping TDATA
        axi_write(4'h4, 32'd0, 4'hF);
        axi_write(4'h8, 32'hFFFFFFFF, 4'hF);
        exp_q.push_back({1'b1, 32'hFFFFFFFF});
        axi_write(4'h0, 32'h1, 4'hF);
        drain("len0");
        axi_write(4'h4, 32'd2, 4'hF);
        exp_q.push_back({1'b0, 32'hFFFFFFFF}); exp_q.push_back({1'b1, 32'h0});
        axi_write(4'h0, 32'h1, 4'hF);
        drain("wrap");
        frames_exp += 2;
        read_check("status_after_wrap", 4'hC, {frames_exp[15:0], 16'h0});

        // Continuous mode, then clear CONT mid-stream
        axi_write(4'h8, 32'h10, 4'hF);
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back({1'b0, 32'h10}); exp_q.push_back({1'b1, 32'h11});
        end
        beats_seen = 0;
        axi_write(4'h0, 32'h3, 4'hF);
        repeat (9) @(posedge clk);
        axi_write(4'h0, 32'h0, 4'hF);
        t = 0;
        do begin @(negedge clk); t++; end while (tvalid && t < 200);
        check("cont_stops", tvalid, 0);
        check("cont_whole_frames", beats_seen % 2, 0);
        check("cont_several_frames", (beats_seen >= 4), 1);
        check("cont_last_tlast", last_tlast, 1);
        check("cont_no_gap", last_cyc - first_cyc + 1, beats_seen);
        exp_q.delete();
        frames_exp += beats_seen / 2;
        read_check("status_after_cont", 4'hC, {frames_exp[15:0], 16'h0});

        // Asynchronous reset during beat 2 of an 8-beat frame
        axi_write(4'h4, 32'd8, 4'hF);
        axi_write(4'h8, 32'h100, 4'hF);
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 32'h100 + 32'(i)});
        beats_seen = 0;
        axi_write(4'h0, 32'h1, 4'hF);
        t = 0;
        do begin @(negedge clk); t++; end while (beats_seen < 1 && t < 20);
        check("reset_frame_started", beats_seen, 1);
        @(posedge clk);
        #2 check("beat2_valid_before_reset", tvalid, 1);
        rst_n = 1'b0;
        #1 check("reset_drops_tvalid", tvalid, 0);
        check("reset_drops_tlast", tlast, 0);
        #4 rst_n = 1'b1;
        exp_q.delete();
        beats_seen = 0;
        read_check("status_after_reset", 4'hC, 32'h0);
        read_check("length_after_reset", 4'h4, 32'h0);
        repeat (20) @(negedge clk);
        check("no_beats_after_reset", beats_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
